// File: rtl/seq_shifter.sv
`timescale 1ns/1ps
// Purpose : bit-serial 16-bit shifter (pass / LSL / LSR / ASR), one bit per clock.
// Latency : shift_amt+1 edges from the accepting edge to done (1 edge for amt=0 or pass).
// Backpressure: none; start is only honoured in IDLE and is silently dropped while busy.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   start      request strobe, accepted only in IDLE
//   shift_in   16-bit operand, captured on the accepting edge
//   shift_op   00 pass, 01 logical left, 10 logical right, 11 arithmetic right
//   shift_amt  bit positions to shift (0-15), captured on the accepting edge
//   busy       high whenever the FSM is not in IDLE
//   done       one-cycle pulse: shift_out holds a new result
//   shift_out  registered result, held until the next result
module seq_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] shift_in,
  input  logic [1:0]  shift_op,
  input  logic [3:0]  shift_amt,
  output logic        busy,
  output logic        done,
  output logic [15:0] shift_out
);

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_LSL  = 2'b01;
  localparam logic [1:0] OP_LSR  = 2'b10;
  localparam logic [1:0] OP_ASR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t      state;
  logic [15:0] work;
  logic [1:0]  op;
  logic [3:0]  cnt;
  logic [15:0] work_next;

  // One-bit step of the captured operation.
  function automatic logic [15:0] shift_one(input logic [15:0] v, input logic [1:0] o);
    logic [15:0] r;
    r = v;
    case (o)
      OP_LSL:  r = {v[14:0], 1'b0};
      OP_LSR:  r = {1'b0, v[15:1]};
      OP_ASR:  r = {v[15], v[15:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign work_next = shift_one(work, op);

  // busy and done are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= 16'h0000;
      op        <= OP_PASS;
      cnt       <= 4'd0;
      shift_out <= 16'h0000;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work <= shift_in;
            op   <= shift_op;
            cnt  <= shift_amt;
            busy <= 1'b1;
            // Nothing to shift: publish the operand straight away.
            if (shift_amt == 4'd0 || shift_op == OP_PASS) begin
              state     <= DONE;
              shift_out <= shift_in;
              done      <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end else begin
            busy <= 1'b0;
          end
        end

        SHIFT: begin
          work <= work_next;
          cnt  <= cnt - 4'd1;
          // cnt==1 means this edge performs the last shift.
          if (cnt == 4'd1) begin
            state     <= DONE;
            shift_out <= work_next;
            done      <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
`timescale 1ns/1ps
module tb_seq_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] shift_in;
  logic [1:0]  shift_op;
  logic [3:0]  shift_amt;
  logic        busy;
  logic        done;
  logic [15:0] shift_out;

  seq_shifter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .shift_in  (shift_in),
    .shift_op  (shift_op),
    .shift_amt (shift_amt),
    .busy      (busy),
    .done      (done),
    .shift_out (shift_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [15:0] model(input logic [15:0] v, input logic [1:0] o, input logic [3:0] a);
    logic signed [15:0] s;
    logic [15:0] r;
    s = v;
    case (o)
      2'b01:   r = v << a;
      2'b10:   r = v >> a;
      2'b11:   r = s >>> a;
      default: r = v;
    endcase
    return r;
  endfunction

  task automatic push_exp(input logic [15:0] v, input logic [1:0] o, input logic [3:0] a);
    exp_t e;
    e.res = model(v, o, a);
    e.lat = (o == 2'b00 || a == 4'd0) ? 1 : int'(a) + 1;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected result and compare against the DUT at a done pulse.
  task automatic check_result(input string tag, input int edges);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard underflow"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, " latency"}, edges, e.lat);
      chk({tag, " result"}, {16'h0, shift_out}, {16'h0, e.res});
      chk({tag, " busy at done"}, {31'h0, busy}, 32'd1);
    end
  endtask

  // Issue one request, wait (bounded) for done, check it, then check the return to IDLE.
  task automatic run_req(input string tag, input logic [15:0] v, input logic [1:0] o,
                         input logic [3:0] a, input bit align);
    int edges;
    bit got;
    logic [15:0] exp_res;
    exp_res = model(v, o, a);
    if (align) @(negedge clk);
    push_exp(v, o, a);
    start = 1'b1; shift_in = v; shift_op = o; shift_amt = a;
    edges = 0; got = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      // Scramble inputs while busy; they must not leak into the result.
      start = 1'b0; shift_in = 16'($urandom); shift_op = 2'($urandom); shift_amt = 4'($urandom);
      if (done) got = 1'b1;
    end
    chk({tag, " done seen"}, {31'h0, got}, 32'd1);
    if (got) begin
      check_result(tag, edges);
      @(posedge clk);
      @(negedge clk);
      chk({tag, " done dropped"}, {31'h0, done}, 32'd0);
      chk({tag, " busy dropped"}, {31'h0, busy}, 32'd0);
      chk({tag, " result held"}, {16'h0, shift_out}, {16'h0, exp_res});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int pulses;
    bit got;

    rst_n = 1'b0; start = 1'b0; shift_in = 16'h0; shift_op = 2'b00; shift_amt = 4'd0;
    #1;
    chk("reset busy", {31'h0, busy}, 32'd0);
    chk("reset done", {31'h0, done}, 32'd0);
    chk("reset shift_out", {16'h0, shift_out}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_req("lsl1",       16'hF0CF, 2'b01, 4'd1,  1'b1);
    run_req("asr4",       16'hF0CF, 2'b11, 4'd4,  1'b1);
    run_req("asr1 pos",   16'h7FFF, 2'b11, 4'd1,  1'b1);
    run_req("lsr15",      16'hC000, 2'b10, 4'd15, 1'b1);
    run_req("asr15 neg",  16'hC000, 2'b11, 4'd15, 1'b1);
    run_req("asr15 pos",  16'h4000, 2'b11, 4'd15, 1'b1);
    run_req("pass amt7",  16'h1234, 2'b00, 4'd7,  1'b1);
    run_req("lsl amt0",   16'hABCD, 2'b01, 4'd0,  1'b1);
    run_req("lsl15",      16'h0003, 2'b01, 4'd15, 1'b1);

    // Back-to-back: start held through a shift, inputs changed while busy.
    @(negedge clk);
    start = 1'b1; shift_in = 16'h0F0F; shift_op = 2'b01; shift_amt = 4'd3;
    push_exp(16'h0F0F, 2'b01, 4'd3);
    edges = 0; got = 1'b0; pulses = 0;
    while (!got && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      shift_in = 16'hFFFF; shift_op = 2'b10; shift_amt = 4'd0;
      if (done) begin got = 1'b1; pulses++; end
    end
    chk("hs done seen", {31'h0, got}, 32'd1);
    check_result("hs first", edges);
    // Still in DONE: present the next request, which must wait for IDLE.
    shift_in = 16'h5555; shift_op = 2'b00; shift_amt = 4'd9;
    @(posedge clk);
    @(negedge clk);
    if (done) pulses++;
    chk("hs single pulse", pulses, 1);
    chk("hs idle busy", {31'h0, busy}, 32'd0);
    push_exp(16'h5555, 2'b00, 4'd9);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("hs second done", {31'h0, done}, 32'd1);
    check_result("hs second", 1);
    @(posedge clk);
    @(negedge clk);
    chk("hs second done dropped", {31'h0, done}, 32'd0);

    // Random requests against the combinational model
    for (int i = 0; i < 8; i++) begin
      run_req($sformatf("rand%0d", i), 16'($urandom), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)), 1'b1);
    end

    // Reset two cycles into an amt=8 shift
    @(negedge clk);
    start = 1'b1; shift_in = 16'h00FF; shift_op = 2'b01; shift_amt = 4'd8;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre-reset busy", {31'h0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset busy", {31'h0, busy}, 32'd0);
    chk("async reset done", {31'h0, done}, 32'd0);
    chk("async reset shift_out", {16'h0, shift_out}, 32'h0);
    pulses = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("no done after reset", pulses, 0);

    // First edge after reset release must accept start
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_req("first edge after reset", 16'hBEEF, 2'b00, 4'd3, 1'b0);

    chk("scoreboard empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
